// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the mem_ctrl slice.
//   state_t     : controller FSM states (IDLE, BUSY, RESP)
//   DEF_*       : default values for the DATA_W / DEPTH / LATENCY parameters
package mem_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// mem_array -- word-organised storage with per-byte write strobes.
// Ports:
//   clk           : clock, writes on rising edge
//   we            : write enable
//   be[DATA_W/8]  : byte strobes, bit i covers wdata[8*i +: 8]
//   waddr, wdata  : write word index / data
//   raddr, rdata  : combinational read port
// Contents start at zero; there is no reset of the array.
module mem_array
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] wmask;

  // Expand byte strobes into a bit mask so a single write port merges
  // new and old bytes in one read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_mask
      assign wmask[gi*8 +: 8] = {8{be[gi]}};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl -- single-outstanding request memory controller with fixed
// response latency.
// Ports:
//   clk, reset            : clock; asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_we                : 1 = write, 0 = read
//   req_addr[32]          : byte address, must be word aligned and in range
//   req_wdata, req_be     : write data and byte strobes
//   rsp_valid             : one-cycle response pulse, LATENCY cycles after accept
//   rsp_rdata             : read data (0 for writes, errors, idle cycles)
//   rsp_err               : misaligned or out-of-range request
// Build option: define MEM_CTRL_BYTE_WRITE_EN to honour req_be; otherwise
// every non-error write updates the whole word.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [31:0] OFF_MASK = 32'(BYTES - 1);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              we_reg;
  logic              err_reg;

  logic [31:0]       word_addr;
  logic              req_err;
  logic              accept;
  logic [BYTES-1:0]  be_eff;
  logic [DATA_W-1:0] rd_word;

  assign word_addr = req_addr >> OFF_W;
  // Range check uses the full word address so high address bits cannot
  // alias back into the array.
  assign req_err   = ((req_addr & OFF_MASK) != 32'd0) || (word_addr >= 32'(DEPTH));
  // Gate with reset so nothing is written while reset holds the FSM in IDLE.
  assign accept    = req_valid && (state_reg == IDLE) && !reset;

`ifdef MEM_CTRL_BYTE_WRITE_EN
  assign be_eff = req_be;
`else
  // Strobes are ignored: OR with all-ones forces full-word writes.
  assign be_eff = req_be | {BYTES{1'b1}};
`endif

  // Writes commit at the accepting edge; the response only reports status.
  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (accept && req_we && !req_err),
    .be    (be_eff),
    .waddr (word_addr[IDX_W-1:0]),
    .wdata (req_wdata),
    .raddr (idx_reg),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      we_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            idx_reg <= word_addr[IDX_W-1:0];
            we_reg  <= req_we;
            err_reg <= req_err;
            if (LATENCY == 1) begin
              state_reg <= RESP;
            end else begin
              state_reg <= BUSY;
              cnt_reg   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= RESP;
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them immediately.
  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_err   = rsp_valid && err_reg;
  assign rsp_rdata = (rsp_valid && !we_reg && !err_reg) ? rd_word : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl -- self-checking bench for mem_ctrl.
// Three instances with LATENCY 1, 3 and 4 share the request bus; each has
// its own req_valid so only the addressed unit sees traffic.
// Expected responses are pushed to a scoreboard when a request is driven
// and popped when rsp_valid is observed.
module tb_mem_ctrl;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_err;
  logic [31:0] rsp_rdata [3];

  int total;
  int bad;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [3][64];
  int          lat_of [3] = '{1, 3, 4};

  mem_ctrl #(.DATA_W(32), .DEPTH(64), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  mem_ctrl #(.DATA_W(32), .DEPTH(64), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  mem_ctrl #(.DATA_W(32), .DEPTH(64), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
`ifdef MEM_CTRL_BYTE_WRITE_EN
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
`else
    r = new_w;
`endif
    return r;
  endfunction

  // Predicted response; also updates the model for committed writes.
  function automatic exp_t predict(input int u, input logic we, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    int   idx;
    e.err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd64);
    idx   = int'((addr >> 2) & 32'd63);
    if (we && !e.err) model[u][idx] = apply_be(model[u][idx], wd, be);
    e.rdata = (!we && !e.err) ? model[u][idx] : 32'h0;
    return e;
  endfunction

  // Full transaction on unit u. Called just after a falling edge.
  task automatic txn(input int u, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    int   lat;
    int   seen;
    int   pulses;
    lat = lat_of[u];
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    req_valid[u] = 1'b1;
    #1;
    total++;
    if (req_ready[u] !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_accept u%0d: got %b want 1", u, req_ready[u]);
    end
    sb.push_back(predict(u, we, addr, wd, be));
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    seen = 0;
    pulses = 0;
    for (int n = 1; n <= lat + 3; n++) begin
      if (n > 1) @(negedge clk);
      total++;
      if (req_ready[u] !== ((n > lat) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL ready_phase u%0d cycle %0d: got %b want %b", u, n, req_ready[u], n > lat);
      end
      if (rsp_valid[u] === 1'b1) begin
        pulses++;
        if (seen == 0) seen = n;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++;
          if (rsp_rdata[u] !== e.rdata || rsp_err[u] !== e.err) begin
            bad++;
            $display("FAIL rsp_data u%0d addr %h: got rdata=%h err=%b want rdata=%h err=%b",
                     u, addr, rsp_rdata[u], rsp_err[u], e.rdata, e.err);
          end
        end
      end else begin
        total++;
        if (rsp_rdata[u] !== 32'h0 || rsp_err[u] !== 1'b0) begin
          bad++;
          $display("FAIL idle_outputs u%0d cycle %0d: got rdata=%h err=%b want 0/0",
                   u, n, rsp_rdata[u], rsp_err[u]);
        end
      end
    end
    total++;
    if (seen != lat || pulses != 1) begin
      bad++;
      $display("FAIL rsp_timing u%0d addr %h: got first=%0d pulses=%0d want first=%0d pulses=1",
               u, addr, seen, pulses, lat);
    end
    $display("txn u%0d we=%b addr=%h wdata=%h be=%h -> rsp at cycle %0d", u, we, addr, wd, be, seen);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    for (int u = 0; u < 3; u++) begin
      total++;
      if (req_ready[u] !== 1'b1 || rsp_valid[u] !== 1'b0 || rsp_rdata[u] !== 32'h0 || rsp_err[u] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state u%0d: got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                 u, req_ready[u], rsp_valid[u], rsp_rdata[u], rsp_err[u]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_basic;
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);       // memory starts at zero
    txn(0, 1'b1, 32'h0000_0008, 32'h0000_0004, 4'hF);
    txn(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF);
    txn(1, 1'b1, 32'h0000_0008, 32'h0000_0004, 4'hF);
    txn(1, 1'b0, 32'h0000_0008, 32'h0, 4'hF);       // 3-cycle read
    txn(0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 4'hF); // last word
    txn(0, 1'b0, 32'h0000_00FC, 32'h0, 4'hF);
  endtask

  task automatic test_errors;
    txn(1, 1'b0, 32'h0000_0006, 32'h0, 4'hF);           // misaligned read
    txn(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);   // out-of-range write
    txn(1, 1'b1, 32'h0000_0009, 32'h1234_5678, 4'hF);   // misaligned write
    txn(1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);           // word 0 untouched by alias
    txn(1, 1'b0, 32'h0000_0008, 32'h0, 4'hF);           // word 2 untouched
  endtask

  task automatic test_byte_write;
    txn(0, 1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF);
    txn(0, 1'b1, 32'h0000_0000, 32'hAABB_CCDD, 4'h5);
    txn(0, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
    txn(0, 1'b1, 32'h0000_0000, 32'h5555_5555, 4'h0);
    txn(0, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid;
    // LATENCY 4 write, reset two cycles after accept: no response, write kept.
    req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'h55; req_be = 4'hF;
    req_valid[2] = 1'b1;
    void'(predict(2, 1'b1, 32'h4, 32'h55, 4'hF));
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_state: got ready=%b valid=%b want 1/0", req_ready[2], rsp_valid[2]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      total++;
      if (rsp_valid[2] !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_dropped cycle %0d: got rsp_valid=%b want 0", n, rsp_valid[2]);
      end
    end
    txn(2, 1'b0, 32'h4, 32'h0, 4'hF);

    // LATENCY 1 read, reset asserted mid-RESP must clear outputs at once.
    req_we = 1'b0; req_addr = 32'h8; req_valid[0] = 1'b1;
    @(posedge clk);
    #2;
    req_valid[0] = 1'b0;
    total++;
    if (rsp_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL resp_before_reset: got rsp_valid=%b want 1", rsp_valid[0]);
    end
    reset = 1'b1;
    #1;
    total++;
    if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'h0 || req_ready[0] !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got valid=%b rdata=%h ready=%b want 0/0/1",
               rsp_valid[0], rsp_rdata[0], req_ready[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    $display("reset mid-transaction checked");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   accepts;
    int   pulses;
    logic prev_rsp;
    accepts = 0; pulses = 0; prev_rsp = 1'b0;
    req_we = 1'b0; req_addr = 32'h8; req_be = 4'hF;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid[0] === 1'b1) begin
        pulses++;
        total++;
        if (prev_rsp) begin
          bad++;
          $display("FAIL b2b_pulse_width cycle %0d: got rsp_valid high twice want single", i);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          total++;
          if (rsp_rdata[0] !== e.rdata || rsp_err[0] !== e.err) begin
            bad++;
            $display("FAIL b2b_data cycle %0d: got %h/%b want %h/%b", i, rsp_rdata[0], rsp_err[0], e.rdata, e.err);
          end
        end
      end
      prev_rsp = rsp_valid[0];
      if (req_ready[0] === 1'b1) begin
        accepts++;
        sb.push_back(predict(0, 1'b0, 32'h8, 32'h0, 4'hF));
      end
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    total++;
    if (accepts != 5 || pulses != 5 || sb.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: got accepts=%0d pulses=%0d left=%0d want 5/5/0", accepts, pulses, sb.size());
    end
    sb.delete();
    $display("back-to-back: accepts=%0d pulses=%0d", accepts, pulses);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req_valid = 3'b000;
    req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    for (int u = 0; u < 3; u++)
      for (int i = 0; i < 64; i++) model[u][i] = 32'h0;
    test_reset;
    test_basic;
    test_errors;
    test_byte_write;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
